// File: rtl/regfile_wb_arbiter.sv
// Register-file write front end: per-source FIFOs feed a round-robin scan that
// issues up to N_WRITE_PORTS writes per cycle with pairwise-distinct addresses.
module regfile_wb_arbiter #(
  parameter int ENTRY_WIDTH   = 32,
  parameter int N_ENTRIES     = 32,
  parameter int N_SRCS        = 4,
  parameter int N_WRITE_PORTS = 2,
  parameter int BUF_DEPTH     = 2,
  parameter int HARDWIRE_ZERO = 1,
  localparam int PTR_WIDTH    = $clog2(N_ENTRIES),
  localparam int CNT_W        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst_aL,
  input  logic [N_SRCS-1:0]                  src_valid_i,
  output logic [N_SRCS-1:0]                  src_ready_o,
  input  logic [N_SRCS*PTR_WIDTH-1:0]        src_addr_i,
  input  logic [N_SRCS*ENTRY_WIDTH-1:0]      src_data_i,
  output logic [N_WRITE_PORTS-1:0]           wr_en_o,
  output logic [N_WRITE_PORTS*PTR_WIDTH-1:0] wr_addr_o,
  output logic [N_WRITE_PORTS*ENTRY_WIDTH-1:0] wr_data_o,
  output logic [N_SRCS*CNT_W-1:0]            occupancy_o
);

  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SRC_W = (N_SRCS > 1) ? $clog2(N_SRCS) : 1;

  logic [PTR_WIDTH-1:0]   mem_addr_q [N_SRCS][BUF_DEPTH];
  logic [ENTRY_WIDTH-1:0] mem_data_q [N_SRCS][BUF_DEPTH];

  logic [IDX_W-1:0] head_q [N_SRCS];
  logic [IDX_W-1:0] head_d [N_SRCS];
  logic [IDX_W-1:0] tail_q [N_SRCS];
  logic [IDX_W-1:0] tail_d [N_SRCS];
  logic [CNT_W-1:0] count_q [N_SRCS];
  logic [CNT_W-1:0] count_d [N_SRCS];
  logic [SRC_W-1:0] rr_q, rr_d;

  logic [N_SRCS-1:0]      push, pop, cand;
  logic [PTR_WIDTH-1:0]   head_addr [N_SRCS];
  logic [ENTRY_WIDTH-1:0] head_data [N_SRCS];

  logic [N_WRITE_PORTS-1:0] port_en;
  logic [PTR_WIDTH-1:0]     port_addr [N_WRITE_PORTS];
  logic [ENTRY_WIDTH-1:0]   port_data [N_WRITE_PORTS];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    return (int'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_SRCS; i++) begin
      head_addr[i]   = mem_addr_q[i][head_q[i]];
      head_data[i]   = mem_data_q[i][head_q[i]];
      cand[i]        = (count_q[i] != '0);
      src_ready_o[i] = (count_q[i] != CNT_W'(BUF_DEPTH)) && rst_aL;
      push[i]        = src_valid_i[i] && src_ready_o[i];
    end
  end

  // Round-robin scan; address-0 heads are dropped without taking a port or moving rr.
  always_comb begin
    logic [SRC_W-1:0] s;
    logic             clash;
    int               n_grant;
    pop     = '0;
    port_en = '0;
    rr_d    = rr_q;
    n_grant = 0;
    s       = '0;
    clash   = 1'b0;
    for (int p = 0; p < N_WRITE_PORTS; p++) begin
      port_addr[p] = '0;
      port_data[p] = '0;
    end
    for (int k = 0; k < N_SRCS; k++) begin
      s     = SRC_W'((int'(rr_q) + k) % N_SRCS);
      clash = 1'b0;
      if (cand[s] && (HARDWIRE_ZERO != 0) && (head_addr[s] == '0)) begin
        pop[s] = 1'b1;
      end else if (cand[s] && (n_grant < N_WRITE_PORTS)) begin
        for (int p = 0; p < N_WRITE_PORTS; p++)
          if (port_en[p] && (port_addr[p] == head_addr[s])) clash = 1'b1;
        if (!clash) begin
          for (int p = 0; p < N_WRITE_PORTS; p++) begin
            if (p == n_grant) begin
              port_en[p]   = 1'b1;
              port_addr[p] = head_addr[s];
              port_data[p] = head_data[s];
            end
          end
          pop[s]  = 1'b1;
          rr_d    = SRC_W'((int'(s) + 1) % N_SRCS);
          n_grant = n_grant + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRCS; i++) begin
      head_d[i]  = pop[i]  ? next_idx(head_q[i]) : head_q[i];
      tail_d[i]  = push[i] ? next_idx(tail_q[i]) : tail_q[i];
      count_d[i] = count_q[i];
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < N_SRCS; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < N_SRCS; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      rr_q <= rr_d;
    end
  end

  // Payload storage is not reset; count gating keeps stale slots invisible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRCS; i++) begin
      if (push[i]) begin
        mem_addr_q[i][tail_q[i]] <= src_addr_i[i*PTR_WIDTH +: PTR_WIDTH];
        mem_data_q[i][tail_q[i]] <= src_data_i[i*ENTRY_WIDTH +: ENTRY_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < N_WRITE_PORTS; p++) begin : g_port
    assign wr_en_o[p]                               = port_en[p];
    assign wr_addr_o[p*PTR_WIDTH +: PTR_WIDTH]      = port_addr[p];
    assign wr_data_o[p*ENTRY_WIDTH +: ENTRY_WIDTH]  = port_data[p];
  end

  for (genvar i = 0; i < N_SRCS; i++) begin : g_occ
    assign occupancy_o[i*CNT_W +: CNT_W] = count_q[i];
  end

endmodule
